// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues req/valid instruction-memory fetches and
// holds the fetched word for decode, with a sticky timeout fault.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int unsigned TIMEOUT   = 8,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enIF,
    input  logic [1:0]  sigPCSrc,
    input  logic [15:0] retAddr,
    output logic        imemReq,
    output logic [15:0] imemAddr,
    input  logic        imemValid,
    input  logic [15:0] imemData,
    output logic [15:0] pc,
    output logic [15:0] instr,
    output logic        instrValid,
    output logic [3:0]  opcode,
    output logic [15:0] linkAddr,
    output logic        busy,
    output logic        fetchFault
);

    localparam int unsigned AW = 16;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state;
    logic          first;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [AW-1:0] next_pc;
    logic [AW-1:0] branch_off;

    // Next-PC selection; the very first fetch after reset always targets RESET_PC.
    always_comb begin
        next_pc    = pc + AW'(1);
        branch_off = {{8{instr[7]}}, instr[7:0]};
        cnt_inc    = cnt + CW'(1);
        if (first) begin
            next_pc = RESET_PC;
        end else begin
            case (sigPCSrc)
                2'b00:   next_pc = pc + AW'(1);
                2'b01:   next_pc = {pc[15:12], instr[11:0]};
                2'b10:   next_pc = pc + branch_off;
                default: next_pc = retAddr;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            linkAddr   <= RESET_PC + AW'(1);
            instr      <= '0;
            first      <= 1'b1;
            cnt        <= '0;
            imemReq    <= 1'b0;
            busy       <= 1'b0;
            instrValid <= 1'b0;
            fetchFault <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (enIF) begin
                        pc         <= next_pc;
                        linkAddr   <= next_pc + AW'(1);
                        first      <= 1'b0;
                        cnt        <= '0;
                        state      <= REQ;
                        imemReq    <= 1'b1;
                        busy       <= 1'b1;
                        instrValid <= 1'b0;
                    end
                end
                REQ: begin
                    // A response arriving on the timeout cycle still wins.
                    if (imemValid) begin
                        instr      <= imemData;
                        state      <= HOLD;
                        imemReq    <= 1'b0;
                        busy       <= 1'b0;
                        instrValid <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == TIMEOUT_C) begin
                            instr      <= NOP_INSTR;
                            fetchFault <= 1'b1;
                            state      <= HOLD;
                            imemReq    <= 1'b0;
                            busy       <= 1'b0;
                            instrValid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    imemReq    <= 1'b0;
                    busy       <= 1'b0;
                    instrValid <= 1'b0;
                end
            endcase
        end
    end

    assign imemAddr = pc;
    assign opcode   = instr[15:12];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// fetch sequences compared against an arithmetic reference model.
module tb_instr_fetch_unit;

    localparam int TO       = 8;
    localparam int RESET_PC = 0;
    localparam int NOP      = 0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enIF = 1'b0;
    logic [1:0]  sigPCSrc = 2'b00;
    logic [15:0] retAddr = 16'h0000;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic        imemValid = 1'b0;
    logic [15:0] imemData = 16'h0000;
    logic [15:0] pc;
    logic [15:0] instr;
    logic        instrValid;
    logic [3:0]  opcode;
    logic [15:0] linkAddr;
    logic        busy;
    logic        fetchFault;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_pc, m_instr;
    bit m_first, m_fault, m_valid;

    // Observations taken one half-cycle after the fetch-start edge
    logic        obs_req, obs_busy, obs_iv, obs_late_req;
    logic [15:0] obs_addr, obs_instr;

    instr_fetch_unit #(.RESET_PC(16'h0000), .TIMEOUT(TO), .NOP_INSTR(16'h0000)) dut (
        .clock(clock), .reset(reset), .enIF(enIF), .sigPCSrc(sigPCSrc),
        .retAddr(retAddr), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemValid(imemValid), .imemData(imemData), .pc(pc), .instr(instr),
        .instrValid(instrValid), .opcode(opcode), .linkAddr(linkAddr),
        .busy(busy), .fetchFault(fetchFault)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    function automatic int ref_next(input int src, input int ret);
        int off;
        if (m_first) return RESET_PC;
        case (src)
            0: return (m_pc + 1) % 65536;
            1: return (m_pc / 4096) * 4096 + (m_instr % 4096);
            2: begin
                off = m_instr % 256;
                if (off >= 128) off = off - 256;
                return (m_pc + off + 65536) % 65536;
            end
            default: return ret;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_instr = 0; m_first = 1; m_fault = 0; m_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // Issue one fetch; memory answers on the lat-th edge after the start edge.
    task automatic run_fetch(input int src, input int ret, input int data, input int lat, input bit noisy);
        @(negedge clock);
        enIF = 1'b1; sigPCSrc = 2'(src); retAddr = 16'(ret);
        @(negedge clock);
        enIF = 1'b0;
        m_pc = ref_next(src, ret); m_first = 0; m_valid = 0;
        obs_req = imemReq; obs_busy = busy; obs_addr = imemAddr; obs_iv = instrValid; obs_instr = instr;
        obs_late_req = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            imemValid = (k == lat);
            imemData  = (k == lat) ? 16'(data) : 16'($urandom);
            enIF      = (noisy && k <= TO) ? 1'($urandom % 2) : 1'b0;
            sigPCSrc  = 2'($urandom);
            retAddr   = 16'($urandom);
            @(negedge clock);
            if (k == TO - 1) obs_late_req = imemReq;
        end
        imemValid = 1'b0; enIF = 1'b0;
        if (lat <= TO) m_instr = data;
        else begin m_instr = NOP; m_fault = 1; end
        m_valid = 1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++; if (imemReq !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imemReq); end
        checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", pc); end
        checks++; if (instr !== 16'h0000) begin failures++; $display("FAIL reset_instr got=%h exp=0000", instr); end
        checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL reset_iv got=%b exp=0", instrValid); end
        checks++; if (linkAddr !== 16'h0001) begin failures++; $display("FAIL reset_link got=%h exp=0001", linkAddr); end
        checks++; if ({busy, fetchFault, opcode} !== 6'd0) begin failures++; $display("FAIL reset_misc got=%b exp=0", {busy, fetchFault, opcode}); end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_first_fetch();
        run_fetch(2, 16'h4444, 16'h1234, 1, 0);
        checks++; if (obs_req !== 1'b1 || obs_busy !== 1'b1) begin failures++; $display("FAIL ff_req got=%b%b exp=11", obs_req, obs_busy); end
        checks++; if (obs_addr !== 16'h0000) begin failures++; $display("FAIL ff_addr got=%h exp=0000", obs_addr); end
        checks++; if (obs_iv !== 1'b0) begin failures++; $display("FAIL ff_iv_early got=%b exp=0", obs_iv); end
        checks++; if (instr !== 16'h1234 || instrValid !== 1'b1) begin failures++; $display("FAIL ff_instr got=%h/%b exp=1234/1", instr, instrValid); end
        checks++; if (opcode !== 4'h1) begin failures++; $display("FAIL ff_opcode got=%h exp=1", opcode); end
        checks++; if (imemReq !== 1'b0) begin failures++; $display("FAIL ff_req_done got=%b exp=0", imemReq); end
    endtask

    task automatic test_branch();
        do_reset();
        run_fetch(0, 0, 16'h1010, 1, 0);
        run_fetch(1, 0, 16'h90FE, 2, 0);
        checks++; if (pc !== 16'h0010) begin failures++; $display("FAIL br_setup got=%h exp=0010", pc); end
        run_fetch(2, 0, 16'h5555, 1, 0);
        checks++; if (obs_addr !== 16'h000E) begin failures++; $display("FAIL br_addr got=%h exp=000E", obs_addr); end
        checks++; if (obs_instr !== 16'h90FE) begin failures++; $display("FAIL br_instr_kept got=%h exp=90FE", obs_instr); end
        checks++; if (pc !== 16'h000E || linkAddr !== 16'h000F) begin failures++; $display("FAIL br_pc_link got=%h/%h exp=000E/000F", pc, linkAddr); end
    endtask

    task automatic test_jump_return();
        run_fetch(3, 16'h3005, 16'h50A0, 3, 0);
        checks++; if (pc !== 16'h3005) begin failures++; $display("FAIL ret1_pc got=%h exp=3005", pc); end
        run_fetch(1, 0, 16'h7000, 1, 0);
        checks++; if (pc !== 16'h30A0 || opcode !== 4'h7) begin failures++; $display("FAIL jmp_pc got=%h/%h exp=30A0/7", pc, opcode); end
        run_fetch(3, 16'h0777, 16'h0000, 1, 0);
        checks++; if (pc !== 16'h0777 || imemAddr !== 16'h0777) begin failures++; $display("FAIL ret2_pc got=%h/%h exp=0777", pc, imemAddr); end
    endtask

    task automatic test_wrap();
        run_fetch(3, 16'hFFFF, 16'h2000, 1, 0);
        checks++; if (linkAddr !== 16'h0000) begin failures++; $display("FAIL wrap_link got=%h exp=0000", linkAddr); end
        run_fetch(0, 0, 16'h2000, 1, 0);
        checks++; if (pc !== 16'h0000 || linkAddr !== 16'h0001) begin failures++; $display("FAIL wrap_pc got=%h/%h exp=0000/0001", pc, linkAddr); end
    endtask

    task automatic test_timeout();
        do_reset();
        run_fetch(0, 0, 16'hABCD, TO, 1);
        checks++; if (instr !== 16'hABCD || fetchFault !== 1'b0) begin failures++; $display("FAIL to_edge got=%h/%b exp=ABCD/0", instr, fetchFault); end
        run_fetch(0, 0, 16'h1111, TO + 3, 1);
        checks++; if (obs_late_req !== 1'b1) begin failures++; $display("FAIL to_still_req got=%b exp=1", obs_late_req); end
        checks++; if (instr !== 16'h0000 || fetchFault !== 1'b1 || instrValid !== 1'b1) begin failures++; $display("FAIL to_fault got=%h/%b/%b exp=0000/1/1", instr, fetchFault, instrValid); end
        checks++; if (pc !== 16'h0001 || imemReq !== 1'b0) begin failures++; $display("FAIL to_pc got=%h/%b exp=0001/0", pc, imemReq); end
        run_fetch(0, 0, 16'h2222, 1, 0);
        checks++; if (fetchFault !== 1'b1 || instr !== 16'h2222) begin failures++; $display("FAIL to_sticky got=%b/%h exp=1/2222", fetchFault, instr); end
    endtask

    task automatic test_reset_mid_req();
        run_fetch(3, 16'h1200, 16'h3333, 1, 0);
        @(negedge clock);
        enIF = 1'b1; sigPCSrc = 2'b11; retAddr = 16'h4567;
        @(negedge clock);
        enIF = 1'b0;
        checks++; if (imemReq !== 1'b1) begin failures++; $display("FAIL mr_req got=%b exp=1", imemReq); end
        #2 reset = 1'b1;
        #1;
        checks++; if (imemReq !== 1'b0 || busy !== 1'b0 || fetchFault !== 1'b0) begin failures++; $display("FAIL mr_async got=%b%b%b exp=000", imemReq, busy, fetchFault); end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        imemValid = 1'b1; imemData = 16'hBEEF;
        @(negedge clock);
        imemValid = 1'b0;
        checks++; if (instrValid !== 1'b0 || instr !== 16'h0000) begin failures++; $display("FAIL mr_discard got=%b/%h exp=0/0000", instrValid, instr); end
        run_fetch(1, 0, 16'h8000, 2, 0);
        checks++; if (obs_addr !== 16'h0000) begin failures++; $display("FAIL mr_refetch got=%h exp=0000", obs_addr); end
    endtask

    task automatic test_random();
        int src, ret, data, lat, prev_instr;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) == 0) do_reset();
            src = int'($urandom_range(0, 3)); ret = int'($urandom % 65536);
            data = int'($urandom % 65536); lat = int'($urandom_range(1, TO + 3));
            prev_instr = m_instr;
            run_fetch(src, ret, data, lat, 1);
            checks++; if (obs_addr !== 16'(m_pc) || obs_req !== 1'b1) begin failures++; $display("FAIL rnd_start it=%0d got=%h/%b exp=%h/1", it, obs_addr, obs_req, 16'(m_pc)); end
            checks++; if (obs_instr !== 16'(prev_instr) || obs_iv !== 1'b0) begin failures++; $display("FAIL rnd_old it=%0d got=%h/%b exp=%h/0", it, obs_instr, obs_iv, 16'(prev_instr)); end
            checks++; if (pc !== 16'(m_pc) || linkAddr !== 16'(m_pc + 1)) begin failures++; $display("FAIL rnd_pc it=%0d got=%h/%h exp=%h/%h", it, pc, linkAddr, 16'(m_pc), 16'(m_pc + 1)); end
            checks++; if (instr !== 16'(m_instr) || opcode !== 4'(m_instr / 4096)) begin failures++; $display("FAIL rnd_instr it=%0d got=%h exp=%h", it, instr, 16'(m_instr)); end
            checks++; if (instrValid !== m_valid || fetchFault !== m_fault || imemReq !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rnd_flags it=%0d got=%b%b%b%b exp=%b%b00", it, instrValid, fetchFault, imemReq, busy, m_valid, m_fault); end
            for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
                imemValid = 1'($urandom); imemData = 16'($urandom);
                @(negedge clock);
            end
            imemValid = 1'b0;
            checks++; if (pc !== 16'(m_pc) || instr !== 16'(m_instr) || instrValid !== 1'b1) begin failures++; $display("FAIL rnd_hold it=%0d got=%h/%h/%b exp=%h/%h/1", it, pc, instr, instrValid, 16'(m_pc), 16'(m_instr)); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_fetch();
        test_branch();
        test_jump_return();
        test_wrap();
        test_timeout();
        test_reset_mid_req();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
